// File: rtl/vga_pixel_fetch.sv
// Framebuffer read stage: streams 8-bpp packed pixels from the cellular RAM
// (asynchronous mode, read-only) through a word FIFO to the VGA timing stage.
module vga_pixel_fetch #(
  parameter logic [25:0] BASE_ADDR   = 26'h0000000,
  parameter int          FRAME_WORDS = 153600,
  parameter int          RD_CYCLES   = 4,
  parameter int          FIFO_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        pix_rd,
  output logic [7:0]  pixel,
  output logic        pix_valid,
  output logic        underflow,
  output logic [26:1] MemAdr,
  input  logic [15:0] MemDB,
  output logic        MemOE,
  output logic        MemWR,
  output logic        RamCS,
  output logic        RamAdv,
  output logic        RamClk,
  output logic        RamCRE,
  output logic        RamLB,
  output logic        RamUB,
  output logic        FlashCS,
  output logic        FlashRp
);

  localparam int IDX_W = $clog2(FRAME_WORDS + 1);
  localparam int CNT_W = (RD_CYCLES > 1) ? $clog2(RD_CYCLES) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [IDX_W-1:0] FW_L     = IDX_W'(FRAME_WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_CYCLES - 1);
  localparam logic [PTR_W:0]   DEPTH_L  = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT1     = (PTR_W + 1)'(1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_READ = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_word_idx;
  logic [IDX_W-1:0]   w_idx_inc;
  logic [IDX_W-1:0]   w_issue_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic [25:0]        r_mem_adr;
  logic               r_ram_cs;
  logic               r_mem_oe;
  logic [15:0]        r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W:0]     r_count;
  logic               r_byte_sel;
  logic               r_underflow;
  logic               w_done;
  logic               w_push;
  logic               w_pop;
  logic               w_valid;
  logic               w_issue;
  logic [15:0]        w_head;

  assign w_idx_inc = r_word_idx + IDX_W'(1);
  assign w_valid   = (r_count != {(PTR_W + 1){1'b0}});
  assign w_done    = (r_state == S_READ) && (r_cnt == CNT_LAST);
  assign w_push    = w_done && !frame_start;
  assign w_pop     = pix_rd && w_valid && r_byte_sel && !frame_start;
  assign w_head    = r_fifo[r_rd_ptr];

  // Issue decision: the in-flight word is counted against FIFO room, and a
  // completing read already counts the word it is pushing.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_issue_idx = r_word_idx;
    if (frame_start) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if ((r_count < DEPTH_L) && (r_word_idx < FW_L)) begin
            w_state_nxt = S_READ;
            w_issue     = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_READ: begin
          if (w_done) begin
            w_issue_idx = w_idx_inc;
            if (((r_count + CNT1) < DEPTH_L) && (w_idx_inc < FW_L)) begin
              w_state_nxt = S_READ;
              w_issue     = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_state_nxt = S_READ;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // RAM access control: address, strobes, access timer and frame word index
  always_ff @(posedge clk) begin
    if (reset || frame_start) begin
      r_mem_adr  <= BASE_ADDR;
      r_ram_cs   <= 1'b1;
      r_mem_oe   <= 1'b1;
      r_cnt      <= {CNT_W{1'b0}};
      r_word_idx <= {IDX_W{1'b0}};
    end else begin
      if (w_done) begin
        r_word_idx <= w_idx_inc;
      end else begin
        r_word_idx <= r_word_idx;
      end
      if (w_issue) begin
        r_mem_adr <= BASE_ADDR + 26'(w_issue_idx);
        r_ram_cs  <= 1'b0;
        r_mem_oe  <= 1'b0;
        r_cnt     <= {CNT_W{1'b0}};
      end else if ((r_state == S_READ) && !w_done) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_ram_cs <= 1'b1;
        r_mem_oe <= 1'b1;
      end
    end
  end

  // FIFO storage; contents need no reset because occupancy is tracked separately
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= MemDB;
    end
  end

  // FIFO pointers, occupancy and byte selector (low byte of each word first)
  always_ff @(posedge clk) begin
    if (reset || frame_start) begin
      r_wr_ptr   <= {PTR_W{1'b0}};
      r_rd_ptr   <= {PTR_W{1'b0}};
      r_count    <= {(PTR_W + 1){1'b0}};
      r_byte_sel <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT1;
        2'b01:   r_count <= r_count - CNT1;
        default: r_count <= r_count;
      endcase
      if (pix_rd && w_valid) begin
        r_byte_sel <= ~r_byte_sel;
      end
    end
  end

  // Sticky underflow flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_underflow <= 1'b0;
    end else if (pix_rd && !w_valid && !frame_start) begin
      r_underflow <= 1'b1;
    end else begin
      r_underflow <= r_underflow;
    end
  end

  assign pixel     = !w_valid ? 8'h00 : (r_byte_sel ? w_head[15:8] : w_head[7:0]);
  assign pix_valid = w_valid;
  assign underflow = r_underflow;
  assign MemAdr    = r_mem_adr;
  assign MemOE     = r_mem_oe;
  assign RamCS     = r_ram_cs;
  assign MemWR     = 1'b1;
  assign RamAdv    = 1'b0;
  assign RamClk    = 1'b0;
  assign RamCRE    = 1'b0;
  assign RamLB     = 1'b0;
  assign RamUB     = 1'b0;
  assign FlashCS   = 1'b1;
  assign FlashRp   = 1'b1;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Self-checking bench for vga_pixel_fetch: a timed RAM model plus a frame-order
// pixel/address reference (word k holds {k+1, k} in its low bytes).
module tb_vga_pixel_fetch;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        pix_rd = 1'b0;
  logic [7:0]  pixel;
  logic        pix_valid, underflow;
  logic [26:1] MemAdr;
  logic [15:0] MemDB;
  logic        MemOE, MemWR, RamCS, RamAdv, RamClk, RamCRE, RamLB, RamUB, FlashCS, FlashRp;

  logic        s_fs = 1'b0;
  logic        s_rd = 1'b0;
  logic [7:0]  s_pixel;
  logic        s_pix_valid, s_underflow;
  logic [26:1] s_MemAdr;
  logic [15:0] s_MemDB;
  logic        s_MemOE, s_MemWR, s_RamCS, s_RamAdv, s_RamClk, s_RamCRE, s_RamLB, s_RamUB, s_FlashCS, s_FlashRp;

  vga_pixel_fetch dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .pix_rd(pix_rd),
    .pixel(pixel), .pix_valid(pix_valid), .underflow(underflow),
    .MemAdr(MemAdr), .MemDB(MemDB), .MemOE(MemOE), .MemWR(MemWR), .RamCS(RamCS),
    .RamAdv(RamAdv), .RamClk(RamClk), .RamCRE(RamCRE), .RamLB(RamLB), .RamUB(RamUB),
    .FlashCS(FlashCS), .FlashRp(FlashRp)
  );

  vga_pixel_fetch #(.FRAME_WORDS(20)) dut_s (
    .clk(clk), .reset(reset), .frame_start(s_fs), .pix_rd(s_rd),
    .pixel(s_pixel), .pix_valid(s_pix_valid), .underflow(s_underflow),
    .MemAdr(s_MemAdr), .MemDB(s_MemDB), .MemOE(s_MemOE), .MemWR(s_MemWR), .RamCS(s_RamCS),
    .RamAdv(s_RamAdv), .RamClk(s_RamClk), .RamCRE(s_RamCRE), .RamLB(s_RamLB), .RamUB(s_RamUB),
    .FlashCS(s_FlashCS), .FlashRp(s_FlashRp)
  );

  // RAM model: data only becomes valid 3.5 clocks after the access starts (70 ns tAA)
  int          age = 0;
  logic        prev_act = 1'b0;
  logic [26:1] prev_adr = 26'd0;
  logic [26:1] rd_q[$];
  always @(negedge clk) begin
    if (!RamCS && !MemOE) begin
      if (!prev_act || (MemAdr != prev_adr)) begin
        age <= 1;
        rd_q.push_back(MemAdr);
      end else begin
        age <= age + 1;
      end
    end else begin
      age <= 0;
    end
    prev_act <= !RamCS && !MemOE;
    prev_adr <= MemAdr;
  end
  assign MemDB = (age >= 4) ? {MemAdr[8:1] + 8'd1, MemAdr[8:1]} : 16'hA5A5;

  logic        s_prev_act = 1'b0;
  logic [26:1] s_prev_adr = 26'd0;
  logic [26:1] s_rd_q[$];
  always @(negedge clk) begin
    if (!s_RamCS && !s_MemOE && (!s_prev_act || (s_MemAdr != s_prev_adr))) begin
      s_rd_q.push_back(s_MemAdr);
    end
    s_prev_act <= !s_RamCS && !s_MemOE;
    s_prev_adr <= s_MemAdr;
  end
  assign s_MemDB = {s_MemAdr[8:1] + 8'd1, s_MemAdr[8:1]};

  // Pixel n of a frame: low byte of word n/2 first, then its high byte.
  function automatic logic [7:0] exp_pix(input int n);
    int w;
    w = n / 2;
    return 8'((w + (n % 2)) % 256);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset = 1'b1; frame_start = 1'b0; pix_rd = 1'b0; s_fs = 1'b0; s_rd = 1'b0;
    repeat (3) tick();
    rd_q.delete();
    s_rd_q.delete();
  endtask

  task automatic test_reset;
    apply_reset();
    checks++;
    if ({MemOE, MemWR, RamCS, RamAdv, RamClk, RamCRE, RamLB, RamUB, FlashCS, FlashRp} !== 10'b1110000011) begin
      failures++; $display("FAIL reset_pins got=%b exp=%b", {MemOE, MemWR, RamCS, RamAdv, RamClk, RamCRE, RamLB, RamUB, FlashCS, FlashRp}, 10'b1110000011);
    end
    checks++;
    if (MemAdr !== 26'd0) begin failures++; $display("FAIL reset_adr got=%0h exp=0", MemAdr); end
    checks++;
    if ({pixel, pix_valid, underflow} !== 10'd0) begin
      failures++; $display("FAIL reset_pixel got=%0h/%b/%b exp=0/0/0", pixel, pix_valid, underflow);
    end
    checks++;
    if ({s_MemOE, s_MemWR, s_RamCS, s_RamAdv, s_RamClk, s_RamCRE, s_RamLB, s_RamUB, s_FlashCS, s_FlashRp, s_pix_valid, s_underflow, s_pixel} !== {10'b1110000011, 10'd0}) begin
      failures++; $display("FAIL reset_small got=%b exp=%b", {s_MemOE, s_MemWR, s_RamCS, s_RamAdv, s_RamClk, s_RamCRE, s_RamLB, s_RamUB, s_FlashCS, s_FlashRp, s_pix_valid, s_underflow, s_pixel}, {10'b1110000011, 10'd0});
    end
  endtask

  task automatic test_fill;
    int   low_cnt, first_high, bad;
    logic wr_ok;
    apply_reset();
    reset = 1'b0;
    low_cnt = 0; first_high = 0; wr_ok = 1'b1; bad = 0;
    checks++;
    if (RamCS !== 1'b1) begin failures++; $display("FAIL fill_cs_at_release got=%b exp=1", RamCS); end
    for (int c = 1; c <= 90; c++) begin
      tick();
      if (RamCS === 1'b0) low_cnt++;
      else if (first_high == 0) first_high = c;
      if (MemWR !== 1'b1) wr_ok = 1'b0;
      if (c == 1) begin
        checks++;
        if ({RamCS, MemOE, MemAdr} !== {2'b00, 26'd0}) begin
          failures++; $display("FAIL first_issue got=%b%b/%0h exp=00/0", RamCS, MemOE, MemAdr);
        end
      end
      if (c == 4) begin
        checks++;
        if (pix_valid !== 1'b0) begin failures++; $display("FAIL valid_before_push got=%b exp=0", pix_valid); end
      end
      if (c == 5) begin
        checks++;
        if ({pix_valid, pixel} !== {1'b1, 8'h00}) begin
          failures++; $display("FAIL valid_after_push got=%b/%0h exp=1/0", pix_valid, pixel);
        end
      end
    end
    checks++;
    if (low_cnt != 64 || first_high != 65) begin
      failures++; $display("FAIL fill_cs_window got=%0d/%0d exp=64/65", low_cnt, first_high);
    end
    checks++;
    if (wr_ok !== 1'b1) begin failures++; $display("FAIL fill_memwr got=0 exp=1"); end
    for (int i = 0; i < rd_q.size(); i++) if (rd_q[i] !== 26'(i)) bad++;
    checks++;
    if (rd_q.size() != 16 || bad != 0) begin
      failures++; $display("FAIL fill_reads got=%0d reads/%0d bad exp=16/0", rd_q.size(), bad);
    end
    checks++;
    if ({pix_valid, pixel} !== {1'b1, 8'h00}) begin
      failures++; $display("FAIL fill_head got=%b/%0h exp=1/0", pix_valid, pixel);
    end
  endtask

  task automatic test_stream;
    int   n;
    logic valid_ok;
    n = 0; valid_ok = 1'b1;
    for (int i = 0; i < 1280; i++) begin
      if (pix_valid !== 1'b1) valid_ok = 1'b0;
      if (i % 2 == 0) begin
        checks++;
        if (pixel !== exp_pix(n)) begin
          failures++; $display("FAIL stream_pixel n=%0d got=%02h exp=%02h", n, pixel, exp_pix(n));
        end
        pix_rd = 1'b1; n++;
      end else begin
        pix_rd = 1'b0;
      end
      tick();
    end
    pix_rd = 1'b0;
    checks++;
    if (valid_ok !== 1'b1) begin failures++; $display("FAIL stream_valid got=0 exp=1"); end
    checks++;
    if (underflow !== 1'b0) begin failures++; $display("FAIL stream_underflow got=%b exp=0", underflow); end
  endtask

  task automatic test_underflow;
    apply_reset();
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if ({pix_valid, underflow} !== 2'b00) begin
      failures++; $display("FAIL uf_pre got=%b%b exp=00", pix_valid, underflow);
    end
    pix_rd = 1'b1;
    tick();
    checks++;
    if (underflow !== 1'b1) begin failures++; $display("FAIL uf_set got=%b exp=1", underflow); end
    repeat (20) tick();
    pix_rd = 1'b0;
    frame_start = 1'b1; tick(); frame_start = 1'b0; tick();
    checks++;
    if (underflow !== 1'b1) begin failures++; $display("FAIL uf_sticky got=%b exp=1", underflow); end
    apply_reset();
    checks++;
    if (underflow !== 1'b0) begin failures++; $display("FAIL uf_reset got=%b exp=0", underflow); end
  endtask

  task automatic test_abort;
    int          c, n, base;
    logic [26:1] a;
    apply_reset();
    reset = 1'b0;
    c = 0; n = 0;
    while (!((RamCS === 1'b0) && (MemAdr === 26'd100)) && (c < 4000)) begin
      if (pix_rd) pix_rd = 1'b0;
      else if (pix_valid === 1'b1) begin
        checks++;
        if (pixel !== exp_pix(n)) begin
          failures++; $display("FAIL abort_pre_pixel n=%0d got=%02h exp=%02h", n, pixel, exp_pix(n));
        end
        pix_rd = 1'b1; n++;
      end
      tick(); c++;
    end
    pix_rd = 1'b0;
    checks++;
    if (c >= 4000) begin failures++; $display("FAIL abort_reach got=timeout exp=read_of_100"); end
    tick();
    frame_start = 1'b1; pix_rd = 1'b1;
    tick();
    frame_start = 1'b0; pix_rd = 1'b0;
    checks++;
    if ({RamCS, MemOE, pix_valid, underflow, MemAdr} !== {4'b1100, 26'd0}) begin
      failures++; $display("FAIL abort_state got=%b%b%b%b/%0h exp=1100/0", RamCS, MemOE, pix_valid, underflow, MemAdr);
    end
    base = rd_q.size();
    a = (base > 0) ? rd_q[base - 1] : 26'h3FFFFFF;
    checks++;
    if (a !== 26'd100) begin failures++; $display("FAIL abort_last_read got=%0d exp=100", a); end
    tick();
    checks++;
    if ({RamCS, MemOE, MemAdr} !== {2'b00, 26'd0}) begin
      failures++; $display("FAIL abort_restart got=%b%b/%0h exp=00/0", RamCS, MemOE, MemAdr);
    end
    c = 0;
    while ((pix_valid !== 1'b1) && (c < 20)) begin tick(); c++; end
    checks++;
    if (c >= 20 || pixel !== exp_pix(0)) begin
      failures++; $display("FAIL abort_first_pixel got=%02h/%0d exp=%02h", pixel, c, exp_pix(0));
    end
    pix_rd = 1'b1; tick(); pix_rd = 1'b0; tick();
    checks++;
    if (pixel !== exp_pix(1)) begin failures++; $display("FAIL abort_second_pixel got=%02h exp=%02h", pixel, exp_pix(1)); end
    a = (rd_q.size() > base) ? rd_q[base] : 26'h3FFFFFF;
    checks++;
    if (a !== 26'd0) begin failures++; $display("FAIL abort_new_read got=%0h exp=0", a); end
  endtask

  task automatic test_random;
    int          n, exp_adr;
    logic        prev_rd, fs, rd;
    logic [26:1] a;
    apply_reset();
    reset = 1'b0;
    n = 0; exp_adr = 0; prev_rd = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      fs = ($urandom_range(0, 399) == 0);
      rd = 1'b0;
      if (!prev_rd && ($urandom_range(0, 2) != 0)) begin
        if (fs) rd = 1'b1;
        else if (pix_valid === 1'b1) begin
          checks++;
          if (pixel !== exp_pix(n)) begin
            failures++; $display("FAIL rand_pixel n=%0d got=%02h exp=%02h", n, pixel, exp_pix(n));
          end
          rd = 1'b1; n++;
        end
      end
      frame_start = fs; pix_rd = rd; prev_rd = rd;
      tick();
      frame_start = 1'b0; pix_rd = 1'b0;
      while (rd_q.size() > 0) begin
        a = rd_q.pop_front();
        checks++;
        if (a !== 26'(exp_adr)) begin failures++; $display("FAIL rand_addr got=%0d exp=%0d", a, exp_adr); end
        exp_adr++;
      end
      if (fs) begin
        exp_adr = 0; n = 0;
        checks++;
        if ({pix_valid, RamCS} !== 2'b01) begin
          failures++; $display("FAIL rand_flush got=%b%b exp=01", pix_valid, RamCS);
        end
      end
    end
    checks++;
    if (underflow !== 1'b0) begin failures++; $display("FAIL rand_underflow got=%b exp=0", underflow); end
  endtask

  task automatic test_frame_end;
    int   n, low_cnt, bad;
    logic prev;
    apply_reset();
    reset = 1'b0;
    n = 0; low_cnt = 0; bad = 0; prev = 1'b0;
    for (int c = 0; c < 400; c++) begin
      s_rd = 1'b0;
      if (!prev && (s_pix_valid === 1'b1)) begin
        checks++;
        if (s_pixel !== exp_pix(n)) begin
          failures++; $display("FAIL end_pixel n=%0d got=%02h exp=%02h", n, s_pixel, exp_pix(n));
        end
        s_rd = 1'b1; n++;
      end
      prev = s_rd;
      tick();
      if (s_RamCS === 1'b0) low_cnt++;
    end
    s_rd = 1'b0;
    for (int i = 0; i < s_rd_q.size(); i++) if (s_rd_q[i] !== 26'(i)) bad++;
    checks++;
    if (s_rd_q.size() != 20 || bad != 0) begin
      failures++; $display("FAIL end_reads got=%0d reads/%0d bad exp=20/0", s_rd_q.size(), bad);
    end
    checks++;
    if (low_cnt != 80 || s_RamCS !== 1'b1) begin
      failures++; $display("FAIL end_cs got=%0d/%b exp=80/1", low_cnt, s_RamCS);
    end
    checks++;
    if (n != 40 || s_pix_valid !== 1'b0 || s_underflow !== 1'b0) begin
      failures++; $display("FAIL end_pops got=%0d/%b/%b exp=40/0/0", n, s_pix_valid, s_underflow);
    end
    s_fs = 1'b1; tick(); s_fs = 1'b0;
    repeat (100) tick();
    bad = 0;
    for (int i = 20; i < s_rd_q.size(); i++) if (s_rd_q[i] !== 26'(i - 20)) bad++;
    checks++;
    if (s_rd_q.size() != 36 || bad != 0) begin
      failures++; $display("FAIL end_restart got=%0d reads/%0d bad exp=36/0", s_rd_q.size(), bad);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stream();
    test_underflow();
    test_abort();
    test_random();
    test_frame_end();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_pixel_fetch.md
Name: vga_pixel_fetch

Overview:
- Framebuffer read stage directly upstream of the VGA timing/colour output in VGA_example.
- Reads 8-bpp packed pixels (two per 16-bit word) from the cellular RAM in asynchronous mode.
- Buffers the words in a small FIFO and presents one pixel per pop request from the VGA timing stage.
- Owns the RAM/flash control pins while the display is running; it never writes the RAM.

Parameters:
- BASE_ADDR, 26'h0000000, word address of pixel (0,0) on MemAdr[26:1].
- FRAME_WORDS, 153600, words per frame (640x480 / 2).
- RD_CYCLES, 4, clk cycles per asynchronous read access (4 x 20 ns = 80 ns ≥ 70 ns tAA).
- FIFO_DEPTH, 16, FIFO depth in 16-bit words (power of two).

Ports:
- clk  in  1  50 MHz system clock.
- reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse at start of vertical blanking; restarts the fetch at BASE_ADDR.
- pix_rd  in  1  pop one pixel; asserted at most every 2nd cycle (25 MHz pixel rate).
- pixel  out  8  head pixel {R[2:0],G[2:0],B[1:0]}; valid when pix_valid=1.
- pix_valid  out  1  FIFO holds at least one unread pixel.
- underflow  out  1  sticky; pix_rd was seen while pix_valid=0.
- MemAdr  out  26  RAM word address [26:1].
- MemDB  in  16  RAM read data (the top level ties the bidir bus and keeps the drivers off).
- MemOE  out  1  output enable, active low.
- MemWR  out  1  write enable, active low; held 1.
- RamCS  out  1  chip select, active low.
- RamAdv  out  1  held 0 (asynchronous mode).
- RamClk  out  1  held 0.
- RamCRE  out  1  held 0.
- RamLB  out  1  held 0.
- RamUB  out  1  held 0.
- FlashCS  out  1  held 1.
- FlashRp  out  1  held 1.

Behaviour:
- Reset values: MemOE=1, MemWR=1, RamCS=1, RamAdv=0, RamClk=0, RamCRE=0, RamLB=0, RamUB=0, FlashCS=1, FlashRp=1, MemAdr=BASE_ADDR, pixel=0, pix_valid=0, underflow=0.
- Internal reset state: FSM=IDLE, word_idx=0, FIFO empty, byte_sel=0.
- After reset, fetching begins immediately; it does not wait for frame_start.
- Issue condition: fifo_count + inflight < FIFO_DEPTH AND word_idx < FRAME_WORDS.
- FSM IDLE:
  - if the issue condition holds, on the next edge: MemAdr <= BASE_ADDR + word_idx, RamCS <= 0, MemOE <= 0, cnt <= 0, go to READ.
  - otherwise RamCS=1 and MemOE=1.
- FSM READ:
  - cnt increments each cycle.
  - At the edge where cnt = RD_CYCLES-1, MemDB is written into the FIFO and word_idx increments.
  - Back-to-back: if the issue condition still holds at that edge (counting the word just pushed), stay in READ with RamCS/MemOE low, MemAdr <= next address, cnt <= 0.
  - Otherwise go to IDLE and drive RamCS/MemOE high.
  - Sustained throughput is 1 word per RD_CYCLES clocks.
- Address arithmetic: 26-bit; word_idx counts 0..FRAME_WORDS-1. At FRAME_WORDS, fetching stops until the next frame_start. There is no wrap.
- FIFO:
  - Show-ahead: pixel = byte_sel ? head[15:8] : head[7:0]; low byte is displayed first.
  - A pushed word makes pix_valid=1 in the cycle after the push edge.
  - Push and pop on the same edge are both honoured.
  - A push never occurs when the FIFO is full; this is guaranteed by the issue condition.
- pix_rd with pix_valid=1:
  - byte_sel=0 -> byte_sel <= 1.
  - byte_sel=1 -> byte_sel <= 0 and the head word is popped.
- pix_rd with pix_valid=0: underflow <= 1, no state change. underflow stays set until reset.
- frame_start has priority over everything except reset:
  - the next edge aborts any read in progress (RamCS=1, MemOE=1, FSM=IDLE, the partial word is discarded);
  - the FIFO is flushed, byte_sel=0, word_idx=0, MemAdr=BASE_ADDR;
  - pix_rd and push in the same cycle are ignored;
  - fetching resumes on the following cycle.
- Reset mid-read: same as frame_start, and additionally restores every reset value listed above.

Test Plan:
- Reset then release, MemDB model returns {addr[8:1]+1, addr[8:1]}, no pix_rd -> exactly 16 reads at addresses 0..15; RamCS/MemOE low continuously for 64 cycles, then high; pix_valid=1; FIFO full.
- From full FIFO, pix_rd every 2nd cycle for 640 pops -> pixels 00,01,01,02,02,03,... in sequence; pix_valid never 0; underflow stays 0.
- Single read timing -> MemOE/RamCS fall the edge after the issue decision; data sampled at the 4th edge; pix_valid rises one cycle after the push; MemWR=1 throughout.
- No pix_rd for 3 cycles after reset, then pix_rd every cycle -> pix_rd while pix_valid=0 sets underflow=1; underflow remains 1 after frame_start.
- frame_start asserted mid-read at word_idx=100 -> next cycle RamCS=1, pix_valid=0; the first new read is at BASE_ADDR; a pix_rd in the frame_start cycle has no effect.
- FRAME_WORDS=20 with continuous popping -> exactly 20 reads, then RamCS stays 1 until frame_start; after frame_start the reads restart at address 0.
